grey_frame_stats: RTL and testbench
===================================

GREY_FRAME_STATS -- requirements
Module: grey_frame_stats

Interface
REQ-001 SHALL have one parameter: MAX_PIX, default 22'h3FFFFF, the pixel-count saturation limit per frame.
REQ-002 SHALL have port iCLK, input, 1 bit: the pixel clock; all state changes on its rising edge.
REQ-003 SHALL have port iRST_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port iFVAL, input, 1 bit: frame valid, high for the whole frame.
REQ-005 SHALL have port iDVAL, input, 1 bit: pixel valid; qualifies iRed, iGreen and iBlue.
REQ-006 SHALL have ports iRed, iGreen and iBlue, inputs, 12 bits each: the processed RGB stream from the equalise/grey stage.
REQ-007 SHALL have port iEN, input, 1 bit: statistics enable; sampled only at frame start.
REQ-008 SHALL have ports oMIN, oMAX and oMEAN, outputs, 12 bits each: luma statistics of the last completed frame.
REQ-009 SHALL have port oPIX_CNT, output, 22 bits: accepted pixel count of the last completed frame.
REQ-010 SHALL have port oSTATS_VALID, output, 1 bit: one-cycle pulse when the statistics outputs update.
REQ-011 SHALL have port oSKIPPED, output, 1 bit: one-cycle pulse when a frame start is ignored.
REQ-012 SHALL have port oOVF, output, 1 bit: the pixel count of the last completed frame saturated.
REQ-013 SHALL have port oBUSY, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL compute luma Y = (R + 2G + B) as a 14-bit sum, keep bits [13:2], and register it with iDVAL and iFVAL in one input stage (Y_d, DVAL_d, FVAL_d).
REQ-015 SHALL detect frame start as the FVAL_d rising edge and frame end as the FVAL_d falling edge; no other FVAL sample is used for edge detection.
REQ-016 SHALL implement four states: IDLE, ACCUM, DIVIDE, DONE.
REQ-017 SHALL, in IDLE on frame start with iEN=1, clear the accumulators (sum=0, cnt=0, min=12'hFFF, max=0) and enter ACCUM; with iEN=0 it SHALL stay in IDLE and leave the outputs unchanged.
REQ-018 SHALL, in ACCUM on each cycle with DVAL_d=1 and cnt<MAX_PIX, add Y_d to the 34-bit sum, increment cnt, and update min and max.
REQ-019 SHALL, when a pixel arrives with cnt==MAX_PIX, drop that pixel and set the internal overflow flag.
REQ-020 SHALL, in ACCUM on frame end, enter DIVIDE; a pixel with DVAL_d=1 on that same cycle SHALL still be accumulated.
REQ-021 SHALL, in DIVIDE, perform restoring division sum/cnt at one dividend bit per cycle for exactly 34 cycles, produce a quotient truncated to 12 bits, and then enter DONE.
REQ-022 SHALL, on entering DIVIDE with cnt==0, skip the division and enter DONE on the next cycle with mean=0, min reported as 0 and max=0.
REQ-023 SHALL, in DONE, register oMIN, oMAX, oMEAN, oPIX_CNT and oOVF, pulse oSTATS_VALID for one cycle, and return to IDLE on the next cycle.
REQ-024 SHALL hold all outputs stable between oSTATS_VALID pulses.
REQ-025 SHALL, on a frame start seen in DIVIDE or DONE, ignore that entire frame and pulse oSKIPPED in the cycle after the edge.
REQ-026 SHALL, on a frame start seen in ACCUM (no intervening frame end), treat the edge as impossible and take no action.
REQ-027 SHALL give a latency from the FVAL_d fall to oSTATS_VALID of 36 cycles for cnt>0 and 2 cycles for cnt==0.

Reset
REQ-028 SHALL, while iRST_N=0, force IDLE with oMIN=0, oMAX=0, oMEAN=0, oPIX_CNT=0, oOVF=0, oSTATS_VALID=0, oSKIPPED=0, oBUSY=0, and all accumulators and the divider cleared.
REQ-029 SHALL, when reset is asserted mid-frame or mid-divide, abandon the frame without pulsing oSTATS_VALID; after release it SHALL wait for the next full frame start.

Verification
REQ-030 SHALL cover: a 4-pixel frame with Y = 100, 200, 300, 400 (R=G=B=Y) -> oMIN=100, oMAX=400, oMEAN=250, oPIX_CNT=4, with oSTATS_VALID 36 cycles after the FVAL_d fall.
REQ-031 SHALL cover: a frame with R=4095, G=0, B=4095 on 10 pixels -> Y=2047, oMEAN=2047, oMIN=oMAX=2047.
REQ-032 SHALL cover: a frame with no iDVAL -> oPIX_CNT=0, oMEAN=0, oMIN=0, oMAX=0, with oSTATS_VALID 2 cycles after the frame end.
REQ-033 SHALL cover: a second frame start arriving 5 cycles after the first frame's end -> oSKIPPED pulse, first frame's stats reported, second frame's stats never reported.
REQ-034 SHALL cover: MAX_PIX=3 with a 5-pixel frame of Y = 10, 20, 30, 40, 50 -> oPIX_CNT=3, oMEAN=20, oMAX=30, oOVF=1.
REQ-035 SHALL cover: iRST_N pulsed low during DIVIDE -> all outputs read 0, no oSTATS_VALID pulse, and the next frame is reported correctly.

Source files
------------

// File: rtl/grey_frame_stats.sv
// grey_frame_stats: per-frame luma statistics (min, max, mean, pixel count)
// for a 12-bit RGB stream. Luma is (R + 2G + B) / 4. The mean comes from a
// serial restoring divider that runs after the frame ends. Results update
// once per accepted frame.
module grey_frame_stats #(
    parameter logic [21:0] MAX_PIX = 22'h3FFFFF
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iFVAL,
    input  logic        iDVAL,
    input  logic [11:0] iRed,
    input  logic [11:0] iGreen,
    input  logic [11:0] iBlue,
    input  logic        iEN,
    output logic [11:0] oMIN,
    output logic [11:0] oMAX,
    output logic [11:0] oMEAN,
    output logic [21:0] oPIX_CNT,
    output logic        oSTATS_VALID,
    output logic        oSKIPPED,
    output logic        oOVF,
    output logic        oBUSY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DIVIDE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // Luma: 14-bit sum, keep bits [13:2]. The fractional bits are dropped.
    logic [13:0] w_luma_sum;
    logic [11:0] w_luma;
    logic [1:0]  w_luma_unused_lsbs;

    // Input stage and edge-detect history
    logic [11:0] r_y_d;
    logic        r_dval_d;
    logic        r_fval_d;
    logic        r_fval_dd;
    logic        r_run;
    logic        r_armed;
    logic        w_rise;
    logic        w_fall;

    // Accumulators
    logic [33:0] r_sum;
    logic [21:0] r_cnt;
    logic [11:0] r_min;
    logic [11:0] r_max;
    logic        r_ovf;
    logic        w_accept;
    logic        w_drop;
    logic [33:0] w_sum_next;
    logic        w_frame_empty;
    logic        w_start;

    // Serial divider
    logic [33:0] r_quo;
    logic [21:0] r_rem;
    logic [5:0]  r_div_cnt;
    logic [23:0] w_diff;
    logic        w_borrow;
    logic        w_diff_unused_bit;
    logic [21:0] w_diff_rem;
    logic        w_div_last;

    // Output registers
    logic [11:0] r_o_min;
    logic [11:0] r_o_max;
    logic [11:0] r_o_mean;
    logic [21:0] r_o_pix_cnt;
    logic        r_o_ovf;
    logic        r_o_valid;
    logic        r_o_skipped;

    assign w_luma_sum = {2'b00, iRed} + {1'b0, iGreen, 1'b0} + {2'b00, iBlue};
    assign {w_luma, w_luma_unused_lsbs} = w_luma_sum;

    // A rising edge counts only after FVAL_d has been seen low since reset.
    // This keeps a frame that is already in flight at reset release from
    // being taken as a new frame.
    assign w_rise = r_armed & r_fval_d & ~r_fval_dd;
    assign w_fall = ~r_fval_d & r_fval_dd;

    assign w_accept      = (r_state == ACCUM) & r_dval_d & (r_cnt < MAX_PIX);
    assign w_drop        = (r_state == ACCUM) & r_dval_d & ~(r_cnt < MAX_PIX);
    assign w_sum_next    = w_accept ? (r_sum + {22'd0, r_y_d}) : r_sum;
    assign w_frame_empty = (r_cnt == 22'd0) & ~w_accept;
    assign w_start       = (r_state == IDLE) & w_rise & iEN;

    assign w_diff = {1'b0, r_rem, r_quo[33]} - {2'b00, r_cnt};
    assign {w_borrow, w_diff_unused_bit, w_diff_rem} = w_diff;
    assign w_div_last = (r_div_cnt == 6'd33);

    // Register luma with its qualifiers, and track FVAL_d history for edges.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_y_d     <= 12'd0;
            r_dval_d  <= 1'b0;
            r_fval_d  <= 1'b0;
            r_fval_dd <= 1'b0;
            r_run     <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_y_d     <= w_luma;
            r_dval_d  <= iDVAL;
            r_fval_d  <= iFVAL;
            r_fval_dd <= r_fval_d;
            r_run     <= 1'b1;
            if (r_run && !r_fval_d) begin
                r_armed <= 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. An empty frame bypasses the divider and goes straight to DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next_state = ACCUM;
                end
            end
            ACCUM: begin
                if (w_fall) begin
                    w_next_state = w_frame_empty ? DONE : DIVIDE;
                end
            end
            DIVIDE: begin
                if (w_div_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Per-frame sum, count, min and max. Excess pixels are dropped and flagged.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_sum <= 34'd0;
            r_cnt <= 22'd0;
            r_min <= 12'd0;
            r_max <= 12'd0;
            r_ovf <= 1'b0;
        end else if (w_start) begin
            r_sum <= 34'd0;
            r_cnt <= 22'd0;
            r_min <= 12'hFFF;
            r_max <= 12'd0;
            r_ovf <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sum <= w_sum_next;
                r_cnt <= r_cnt + 22'd1;
                if (r_y_d < r_min) begin
                    r_min <= r_y_d;
                end
                if (r_y_d > r_max) begin
                    r_max <= r_y_d;
                end
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Restoring divider. It loads the final sum (including a pixel that lands
    // on the frame-end cycle), then produces one quotient bit per cycle.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_quo     <= 34'd0;
            r_rem     <= 22'd0;
            r_div_cnt <= 6'd0;
        end else if ((r_state == ACCUM) && w_fall && !w_frame_empty) begin
            r_quo     <= w_sum_next;
            r_rem     <= 22'd0;
            r_div_cnt <= 6'd0;
        end else if (r_state == DIVIDE) begin
            r_quo     <= {r_quo[32:0], ~w_borrow};
            r_rem     <= w_borrow ? {r_rem[20:0], r_quo[33]} : w_diff_rem;
            r_div_cnt <= r_div_cnt + 6'd1;
        end
    end

    // Publish results in DONE and generate the one-cycle status pulses.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_o_min     <= 12'd0;
            r_o_max     <= 12'd0;
            r_o_mean    <= 12'd0;
            r_o_pix_cnt <= 22'd0;
            r_o_ovf     <= 1'b0;
            r_o_valid   <= 1'b0;
            r_o_skipped <= 1'b0;
        end else begin
            r_o_valid   <= (r_state == DONE);
            r_o_skipped <= w_rise & ((r_state == DIVIDE) | (r_state == DONE));
            if (r_state == DONE) begin
                r_o_min     <= (r_cnt == 22'd0) ? 12'd0 : r_min;
                r_o_max     <= r_max;
                r_o_mean    <= (r_cnt == 22'd0) ? 12'd0 : r_quo[11:0];
                r_o_pix_cnt <= r_cnt;
                r_o_ovf     <= r_ovf;
            end
        end
    end

    assign oMIN         = r_o_min;
    assign oMAX         = r_o_max;
    assign oMEAN        = r_o_mean;
    assign oPIX_CNT     = r_o_pix_cnt;
    assign oOVF         = r_o_ovf;
    assign oSTATS_VALID = r_o_valid;
    assign oSKIPPED     = r_o_skipped;
    assign oBUSY        = (r_state != IDLE);

endmodule

// File: tb/tb_grey_frame_stats.sv
// Directed testbench for grey_frame_stats. A default instance and a
// MAX_PIX=3 instance share one input stream. Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_grey_frame_stats;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic        iFVAL;
    logic        iDVAL;
    logic [11:0] iRed;
    logic [11:0] iGreen;
    logic [11:0] iBlue;
    logic        iEN;

    logic [11:0] oMIN, oMAX, oMEAN;
    logic [21:0] oPIX_CNT;
    logic        oSTATS_VALID, oSKIPPED, oOVF, oBUSY;

    logic [11:0] sMIN, sMAX, sMEAN;
    logic [21:0] sPIX_CNT;
    logic        sSTATS_VALID, sSKIPPED, sOVF, sBUSY;

    int errors = 0;
    int checks = 0;

    grey_frame_stats dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iFVAL(iFVAL), .iDVAL(iDVAL),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iEN(iEN),
        .oMIN(oMIN), .oMAX(oMAX), .oMEAN(oMEAN), .oPIX_CNT(oPIX_CNT),
        .oSTATS_VALID(oSTATS_VALID), .oSKIPPED(oSKIPPED), .oOVF(oOVF), .oBUSY(oBUSY)
    );

    grey_frame_stats #(.MAX_PIX(22'd3)) dutSat (
        .iCLK(iCLK), .iRST_N(iRST_N), .iFVAL(iFVAL), .iDVAL(iDVAL),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iEN(iEN),
        .oMIN(sMIN), .oMAX(sMAX), .oMEAN(sMEAN), .oPIX_CNT(sPIX_CNT),
        .oSTATS_VALID(sSTATS_VALID), .oSKIPPED(sSKIPPED), .oOVF(sOVF), .oBUSY(sBUSY)
    );

    always #5 iCLK = ~iCLK;

    task automatic checkOutput(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic fval, input logic dval,
                                 input logic [11:0] r, input logic [11:0] g, input logic [11:0] b);
        @(negedge iCLK);
        iFVAL  = fval;
        iDVAL  = dval;
        iRed   = r;
        iGreen = g;
        iBlue  = b;
    endtask

    // Two blank FVAL cycles, n pixels with colour start+k*step, then FVAL low.
    // With lastOnFall the final pixel is presented together with FVAL low.
    task automatic sendFrame(input int n, input int r0, input int g0, input int b0,
                             input int step, input bit lastOnFall);
        applyStimulus(1'b1, 1'b0, 12'd0, 12'd0, 12'd0);
        applyStimulus(1'b1, 1'b0, 12'd0, 12'd0, 12'd0);
        for (int k = 0; k < n; k++) begin
            applyStimulus(!(lastOnFall && (k == n - 1)), 1'b1,
                          12'(r0 + k * step), 12'(g0 + k * step), 12'(b0 + k * step));
        end
        if (!lastOnFall || n == 0) begin
            applyStimulus(1'b0, 1'b0, 12'd0, 12'd0, 12'd0);
        end
    endtask

    // Count falling edges from the FVAL-low drive until oSTATS_VALID appears.
    task automatic waitStats(input string tag, input int expLat);
        int lat;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge iCLK);
            iDVAL = 1'b0;
            if (oSTATS_VALID) begin
                lat = i;
                break;
            end
        end
        checkOutput({tag, "_latency"}, 36'(lat), 36'(expLat));
    endtask

    task automatic checkStats(input string tag, input int mn, input int mx, input int mean,
                              input int cnt, input int ovf);
        checkOutput({tag, "_min"},  36'(oMIN),     36'(mn));
        checkOutput({tag, "_max"},  36'(oMAX),     36'(mx));
        checkOutput({tag, "_mean"}, 36'(oMEAN),    36'(mean));
        checkOutput({tag, "_cnt"},  36'(oPIX_CNT), 36'(cnt));
        checkOutput({tag, "_ovf"},  36'(oOVF),     36'(ovf));
    endtask

    task automatic checkZero(input string tag);
        checkStats(tag, 0, 0, 0, 0, 0);
        checkOutput({tag, "_valid"}, 36'(oSTATS_VALID), 36'd0);
        checkOutput({tag, "_skip"},  36'(oSKIPPED),     36'd0);
        checkOutput({tag, "_busy"},  36'(oBUSY),        36'd0);
        checkOutput({tag, "_sat_cnt"}, 36'(sPIX_CNT), 36'd0);
        checkOutput({tag, "_sat_ovf"}, 36'(sOVF),     36'd0);
    endtask

    initial begin
        int nValid;
        int nSkip;
        logic [11:0] capMin, capMax, capMean;
        logic [21:0] capCnt;

        iRST_N = 1'b0;
        iFVAL  = 1'b0;
        iDVAL  = 1'b0;
        iRed   = 12'd0;
        iGreen = 12'd0;
        iBlue  = 12'd0;
        iEN    = 1'b1;

        // Reset values
        repeat (3) @(negedge iCLK);
        checkZero("reset");
        iRST_N = 1'b1;
        repeat (3) @(negedge iCLK);

        // Four pixels of Y = 100..400
        sendFrame(4, 100, 100, 100, 100, 1'b0);
        checkOutput("f1_busy_accum", 36'(oBUSY), 36'd1);
        waitStats("f1", 37);
        checkStats("f1", 100, 400, 250, 4, 0);
        @(negedge iCLK);
        checkOutput("f1_pulse_width", 36'(oSTATS_VALID), 36'd0);
        checkOutput("f1_busy_idle", 36'(oBUSY), 36'd0);
        repeat (5) @(negedge iCLK);
        checkOutput("f1_hold_mean", 36'(oMEAN), 36'd250);

        // R=4095 G=0 B=4095 gives Y=2047; the tenth pixel arrives on the frame-end cycle
        sendFrame(10, 4095, 0, 4095, 0, 1'b1);
        waitStats("f2", 37);
        checkStats("f2", 2047, 2047, 2047, 10, 0);

        // Frame with no valid pixels
        repeat (3) @(negedge iCLK);
        sendFrame(0, 0, 0, 0, 0, 1'b0);
        waitStats("f3", 3);
        checkStats("f3", 0, 0, 0, 0, 0);

        // Second frame starts 5 cycles after the first ends, while the divider is busy
        nValid  = 0;
        nSkip   = 0;
        capMin  = 12'd0;
        capMax  = 12'd0;
        capMean = 12'd0;
        capCnt  = 22'd0;
        repeat (3) @(negedge iCLK);
        for (int c = 0; c < 80; c++) begin
            @(negedge iCLK);
            if (oSTATS_VALID) begin
                nValid++;
                capMin  = oMIN;
                capMax  = oMAX;
                capMean = oMEAN;
                capCnt  = oPIX_CNT;
            end
            if (oSKIPPED) begin
                nSkip++;
            end
            iFVAL = (c <= 2) || (c >= 8 && c <= 10);
            iDVAL = (c == 1) || (c == 2) || (c >= 8 && c <= 10);
            iRed  = (c == 1) ? 12'd5 : (c == 2) ? 12'd7 : (c >= 8) ? 12'd1000 : 12'd0;
            iGreen = iRed;
            iBlue  = iRed;
        end
        checkOutput("skip_pulses", 36'(nSkip), 36'd1);
        checkOutput("skip_valid_count", 36'(nValid), 36'd1);
        checkOutput("skip_min", 36'(capMin), 36'd5);
        checkOutput("skip_max", 36'(capMax), 36'd7);
        checkOutput("skip_mean", 36'(capMean), 36'd6);
        checkOutput("skip_cnt", 36'(capCnt), 36'd2);
        checkOutput("skip_busy_end", 36'(oBUSY), 36'd0);

        // Y = 10..50 on both instances; the MAX_PIX=3 one saturates
        applyStimulus(1'b0, 1'b0, 12'd0, 12'd0, 12'd0);
        sendFrame(5, 10, 10, 10, 10, 1'b0);
        waitStats("f5", 37);
        checkStats("f5", 10, 50, 30, 5, 0);
        checkOutput("sat_valid", 36'(sSTATS_VALID), 36'd1);
        checkOutput("sat_cnt",  36'(sPIX_CNT), 36'd3);
        checkOutput("sat_mean", 36'(sMEAN), 36'd20);
        checkOutput("sat_max",  36'(sMAX), 36'd30);
        checkOutput("sat_min",  36'(sMIN), 36'd10);
        checkOutput("sat_ovf",  36'(sOVF), 36'd1);

        // Reset asserted while dividing
        repeat (3) @(negedge iCLK);
        sendFrame(2, 50, 50, 50, 10, 1'b0);
        repeat (10) @(negedge iCLK);
        checkOutput("rst_busy_div", 36'(oBUSY), 36'd1);
        iRST_N = 1'b0;
        #1;
        checkZero("rst_mid");
        @(negedge iCLK);
        iRST_N = 1'b1;
        nValid = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge iCLK);
            if (oSTATS_VALID) nValid++;
        end
        checkOutput("rst_no_valid", 36'(nValid), 36'd0);
        checkOutput("rst_mean_zero", 36'(oMEAN), 36'd0);
        sendFrame(3, 8, 8, 8, 4, 1'b0);
        waitStats("f7", 37);
        checkStats("f7", 8, 16, 12, 3, 0);

        // Frame start with the enable low is ignored and outputs stay put
        repeat (3) @(negedge iCLK);
        iEN = 1'b0;
        sendFrame(2, 999, 999, 999, 0, 1'b0);
        iEN = 1'b1;
        nValid = 0;
        nSkip  = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge iCLK);
            if (oSTATS_VALID) nValid++;
            if (oSKIPPED) nSkip++;
        end
        checkOutput("en0_no_valid", 36'(nValid), 36'd0);
        checkOutput("en0_no_skip", 36'(nSkip), 36'd0);
        checkStats("en0_hold", 8, 16, 12, 3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
